vlc_bit_packer: RTL and testbench

Bit packer placed directly downstream of the DC/AC entropy coders. It accepts variable-length codewords as (value, length) pairs and concatenates them MSB-first into a continuous bitstream. Completed 32-bit words are emitted through a small output FIFO with valid/ready backpressure to the slice writer. A flush request zero-pads the final partial word and marks it as the last word of the slice.

---
 rtl/vlc_pkg.sv | 21 ++
 rtl/vlc_word_fifo.sv | 65 ++++++
 rtl/vlc_bit_packer.sv | 144 ++++++++++++++
 tb/tb_vlc_bit_packer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_pkg.sv
// Shared constants and types for the VLC bit packer and the entropy coders feeding it.
package vlc_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ACC_W   = 64;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned FILL_W  = 7;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PAD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } word_t;

endpackage

// File: rtl/vlc_word_fifo.sv
// Show-ahead synchronous FIFO holding packed output words; head entry is always visible on rd_data.
module vlc_word_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is allowed only when the head leaves on the same edge.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/vlc_bit_packer.sv
// Concatenates (value, length) codewords MSB-first into 32-bit words, with flush/zero-pad
// of the final partial word and a small backpressured output FIFO.
module vlc_bit_packer
  import vlc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_code,
  input  logic [31:0]       in_len,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              flush_done,
  output logic [31:0]       bit_count,
  output logic              len_err
);

  state_t             state;
  state_t             state_next;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   acc_base;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_next;
  logic [FILL_W-1:0]  fill_base;
  logic [ACC_W-1:0]   code_mask;
  logic [ACC_W-1:0]   code_left;
  logic [FILL_W-1:0]  left_shamt;
  logic               len_ok;
  logic               take;
  logic               accept;
  logic               bad_len;
  logic               emit;
  logic               pad_push;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  word_t              push_entry;
  word_t              head_entry;

  // Datapath: emit a full word, then merge the incoming codeword behind whatever remains.
  always_comb begin
    len_ok     = (in_len <= 32'(MAX_LEN));
    take       = in_valid && in_ready && !((state == RUN) && flush);
    accept     = take && len_ok;
    bad_len    = take && !len_ok;

    code_mask  = (ACC_W'(1) << in_len[5:0]) - ACC_W'(1);
    left_shamt = FILL_W'(ACC_W) - {1'b0, in_len[5:0]};
    code_left  = (ACC_W'(in_code) & code_mask) << left_shamt;

    emit       = (fill >= FILL_W'(WORD_W)) && !fifo_full && ((state == RUN) || (state == DRAIN));
    pad_push   = (state == PAD) && !fifo_full;

    acc_base   = emit ? (acc << WORD_W) : acc;
    fill_base  = emit ? (fill - FILL_W'(WORD_W)) : fill;
    acc_next   = acc_base;
    fill_next  = fill_base;

    if (accept) begin
      acc_next  = acc_base | (code_left >> fill_base);
      fill_next = fill_base + FILL_W'(in_len[5:0]);
    end
    if (pad_push || (state == DONE)) begin
      acc_next  = '0;
      fill_next = '0;
    end

    fifo_push       = emit || pad_push;
    push_entry.last = pad_push;
    push_entry.data = acc[ACC_W-1 -: WORD_W];
  end

  // Flush sequencing: drain whole words, pad any remainder, then report completion.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (flush) state_next = DRAIN;
      end
      DRAIN: begin
        if (fill >= FILL_W'(WORD_W)) state_next = DRAIN;
        else if (fill != '0)         state_next = PAD;
        else                         state_next = DONE;
      end
      PAD: begin
        if (!fifo_full) state_next = DONE;
      end
      DONE: begin
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      acc        <= '0;
      fill       <= '0;
      in_ready   <= 1'b0;
      flush_done <= 1'b0;
      bit_count  <= '0;
      len_err    <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      fill       <= fill_next;
      in_ready   <= (state_next == RUN) && (fill_next < FILL_W'(WORD_W));
      flush_done <= (state_next == DONE);
      if (accept) begin
        bit_count <= bit_count + in_len;
      end
      if (bad_len) begin
        len_err <= 1'b1;
      end
    end
  end

  vlc_word_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wr_data (push_entry),
    .pop     (out_ready),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head_entry.data;
  assign out_last  = head_entry.last;

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed self-checking bench for vlc_bit_packer.
module tb_vlc_bit_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_code;
  logic [31:0] in_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        flush_done;
  logic [31:0] bit_count;
  logic        len_err;

  int total = 0;
  int bad   = 0;

  logic [31:0] got_data [$];
  logic        got_last [$];
  int          done_cnt;

  always #5 clk = ~clk;

  vlc_bit_packer #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_len     (in_len),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .flush_done (flush_done),
    .bit_count  (bit_count),
    .len_err    (len_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    in_len    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] code, input logic [31:0] len);
    int n = 0;
    in_code  = code;
    in_len   = len;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else begin
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Drains the output for a fixed window, recording words and flush_done pulses.
  task automatic collect(input int cycles);
    got_data.delete();
    got_last.delete();
    done_cnt  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      if (out_valid === 1'b1) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (flush_done === 1'b1) done_cnt++;
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_code = '0; in_len = '0; flush = 1'b0; out_ready = 1'b0;
    step();
    total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 32'h0)   begin bad++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    total++; if (out_last !== 1'b0)    begin bad++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    total++; if (flush_done !== 1'b0)  begin bad++; $display("FAIL rst_flush_done: got %b want 0", flush_done); end
    total++; if (bit_count !== 32'h0)  begin bad++; $display("FAIL rst_bit_count: got %0d want 0", bit_count); end
    total++; if (len_err !== 1'b0)     begin bad++; $display("FAIL rst_len_err: got %b want 0", len_err); end
    reset_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic_word();
    do_reset();
    send(32'hAB, 32'd8);
    send(32'hCD, 32'd8);
    send(32'hEF, 32'd8);
    send(32'h01, 32'd8);
    total++; if (bit_count !== 32'd32) begin bad++; $display("FAIL basic_bit_count: got %0d want 32", bit_count); end
    collect(10);
    total++; if (got_data.size() != 1) begin bad++; $display("FAIL basic_word_count: got %0d want 1", got_data.size()); end
    else begin
      total++; if (got_data[0] !== 32'hABCDEF01) begin bad++; $display("FAIL basic_data: got %h want abcdef01", got_data[0]); end
      total++; if (got_last[0] !== 1'b0) begin bad++; $display("FAIL basic_last: got %b want 0", got_last[0]); end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_empty: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    send(32'hABCDE, 32'd20);
    send(32'h12345, 32'd20);
    pulse_flush();
    collect(20);
    total++; if (got_data.size() != 2) begin bad++; $display("FAIL flush_word_count: got %0d want 2", got_data.size()); end
    else begin
      total++; if (got_data[0] !== 32'hABCDE123) begin bad++; $display("FAIL flush_word0: got %h want abcde123", got_data[0]); end
      total++; if (got_last[0] !== 1'b0) begin bad++; $display("FAIL flush_last0: got %b want 0", got_last[0]); end
      total++; if (got_data[1] !== 32'h45000000) begin bad++; $display("FAIL flush_word1: got %h want 45000000", got_data[1]); end
      total++; if (got_last[1] !== 1'b1) begin bad++; $display("FAIL flush_last1: got %b want 1", got_last[1]); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL flush_done_pulses: got %0d want 1", done_cnt); end
    total++; if (bit_count !== 32'd40) begin bad++; $display("FAIL flush_bit_count: got %0d want 40", bit_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) send(32'hFFFFFFFF, 32'd32);
    step();
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    total++; if (bit_count !== 32'd160) begin bad++; $display("FAIL bp_bit_count: got %0d want 160", bit_count); end
    collect(30);
    total++; if (got_data.size() != 5) begin bad++; $display("FAIL bp_word_count: got %0d want 5", got_data.size()); end
    for (int i = 0; i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== 32'hFFFFFFFF || got_last[i] !== 1'b0) begin
        bad++; $display("FAIL bp_word%0d: got %h/%b want ffffffff/0", i, got_data[i], got_last[i]);
      end
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_back: got %b want 1", in_ready); end
  endtask

  task automatic test_len_err();
    do_reset();
    send(32'h1FF, 32'd33);
    step();
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL lenerr_flag: got %b want 1", len_err); end
    total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL lenerr_bit_count: got %0d want 0", bit_count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lenerr_out_valid: got %b want 0", out_valid); end
    send(32'hFFFFFFFF, 32'd0);
    step();
    total++; if (bit_count !== 32'd0) begin bad++; $display("FAIL len0_bit_count: got %0d want 0", bit_count); end
    total++; if (len_err !== 1'b1) begin bad++; $display("FAIL len0_len_err: got %b want 1", len_err); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL len0_in_ready: got %b want 1", in_ready); end
    send(32'h12345678, 32'd32);
    collect(10);
    total++; if (got_data.size() != 1 || got_data[0] !== 32'h12345678) begin
      bad++; $display("FAIL len0_followup: got %0d words, first %h want 1 word 12345678",
                      got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0);
    end
  endtask

  task automatic test_masking();
    do_reset();
    send(32'hFFFFFF03, 32'd2);
    send(32'h3FFFFFFF, 32'd30);
    for (int i = 0; i < 8; i++) send(32'hFFFFFFF0, 32'd4);
    collect(12);
    total++; if (got_data.size() != 2) begin bad++; $display("FAIL mask_word_count: got %0d want 2", got_data.size()); end
    else begin
      total++; if (got_data[0] !== 32'hFFFFFFFF) begin bad++; $display("FAIL mask_word0: got %h want ffffffff", got_data[0]); end
      total++; if (got_data[1] !== 32'h00000000) begin bad++; $display("FAIL mask_word1: got %h want 00000000", got_data[1]); end
    end
    total++; if (bit_count !== 32'd64) begin bad++; $display("FAIL mask_bit_count: got %0d want 64", bit_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(32'hFFFFFFFF, 32'd32);
    send(32'hFFFFFFFF, 32'd32);
    send(32'h1ABCD, 32'd17);
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL mid_async_data: got %h want 0", out_data); end
    total++; if (bit_count !== 32'h0) begin bad++; $display("FAIL mid_async_bit_count: got %0d want 0", bit_count); end
    step();
    reset_n = 1'b1;
    send(32'h12345678, 32'd32);
    collect(10);
    total++; if (got_data.size() != 1 || got_data[0] !== 32'h12345678 || got_last[0] !== 1'b0) begin
      bad++; $display("FAIL mid_clean_word: got %0d words, first %h want 1 word 12345678",
                      got_data.size(), (got_data.size() > 0) ? got_data[0] : 32'h0);
    end
    pulse_flush();
    collect(10);
    total++; if (got_data.size() != 0) begin bad++; $display("FAIL empty_flush_words: got %0d want 0", got_data.size()); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL empty_flush_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_word();
    test_flush();
    test_backpressure();
    test_len_err();
    test_masking();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
